aes_seq_ctrl: RTL and testbench

- Host-facing controller for an iterative AES-128 encryption datapath.
- Assembles 128-bit key and plaintext from 4-bit host nibbles under a command code, then sequences the external round core: initial AddRoundKey, then NROUNDS rounds, each with a request/acknowledge handshake.
- Captures the ciphertext and streams it back to the host one byte per read command.
- Sits between the board-level nibble/command inputs and the combinational/multicycle round datapath.

---
 rtl/aes_seq_ctrl_pkg.sv | 22 ++
 rtl/aes_seq_ctrl_nibble_loader.sv | 26 ++
 rtl/aes_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_aes_seq_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_ctrl_pkg.sv
// Shared definitions for the AES-128 sequencing controller: host command codes,
// controller state encoding and default geometry.
package aes_pkg;

  localparam int unsigned BLK_W_DEF   = 128;
  localparam int unsigned NROUNDS_DEF = 10;

  localparam logic [3:0] CMD_LOAD_KEY  = 4'd0;
  localparam logic [3:0] CMD_LOAD_TEXT = 4'd1;
  localparam logic [3:0] CMD_START     = 4'd2;
  localparam logic [3:0] CMD_READ      = 4'd3;
  localparam logic [3:0] CMD_CLEAR     = 4'd4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    STEP    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/aes_seq_ctrl_nibble_loader.sv
// MSB-first nibble shift register with a load counter that saturates at one
// full block, so "block complete" survives over-long load sequences.
module aes_nibble_loader #(
  parameter  int unsigned BLK_W = 128,
  localparam int unsigned NIBS  = BLK_W / 4,
  localparam int unsigned CW    = $clog2(NIBS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [3:0]       nib,
  output logic [BLK_W-1:0] data,
  output logic [CW-1:0]    cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      cnt  <= '0;
    end else if (load) begin
      data <= {data[BLK_W-5:0], nib};
      if (cnt != CW'(NIBS)) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/aes_seq_ctrl.sv
// Host-side sequencer for an iterative AES-128 round core: nibble loading,
// round request/acknowledge sequencing and byte-wise ciphertext readout.
module aes_seq_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NROUNDS = NROUNDS_DEF,
  parameter int unsigned BLK_W   = BLK_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       in,
  input  logic [3:0]       cs,
  input  logic             in_valid,
  output logic [7:0]       out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [BLK_W-1:0] key_o,
  output logic [BLK_W-1:0] text_o,
  output logic             core_init,
  output logic             core_step,
  output logic [3:0]       core_round,
  output logic             core_final,
  input  logic             core_ack,
  input  logic [BLK_W-1:0] core_result
);

  localparam int unsigned NIBS  = BLK_W / 4;
  localparam int unsigned BYTES = BLK_W / 8;
  localparam int unsigned CW    = $clog2(NIBS + 1);
  localparam int unsigned BCW   = $clog2(BYTES + 1);

  state_t           state;
  logic [3:0]       r;
  logic [BLK_W-1:0] result;
  logic [BLK_W-1:0] shifted;
  logic [BCW-1:0]   bcnt;
  logic [CW-1:0]    kcnt;
  logic [CW-1:0]    tcnt;
  logic             clear;
  logic             loadable;
  logic             load_key;
  logic             load_text;
  logic             start_ok;
  logic             read_ok;
  logic             last_byte;

  always_comb begin
    clear     = in_valid && (cs == CMD_CLEAR);
    loadable  = (state == IDLE) || (state == DONE);
    load_key  = in_valid && (cs == CMD_LOAD_KEY) && loadable;
    load_text = in_valid && (cs == CMD_LOAD_TEXT) && loadable;
    start_ok  = in_valid && (cs == CMD_START) && loadable &&
                (kcnt == CW'(NIBS)) && (tcnt == CW'(NIBS));
    read_ok   = in_valid && (cs == CMD_READ) && (state == DONE) && out_valid;
    last_byte = (bcnt == BCW'(BYTES - 1));
    shifted   = result << 8;
  end

  // CLEAR wipes the loaders exactly like rst, so a following START is refused.
  aes_nibble_loader #(.BLK_W(BLK_W)) u_key_loader (
    .clk  (clk),
    .rst  (rst || clear),
    .load (load_key),
    .nib  (in),
    .data (key_o),
    .cnt  (kcnt)
  );

  aes_nibble_loader #(.BLK_W(BLK_W)) u_text_loader (
    .clk  (clk),
    .rst  (rst || clear),
    .load (load_text),
    .nib  (in),
    .data (text_o),
    .cnt  (tcnt)
  );

  always_comb begin
    busy       = (state == INIT) || (state == STEP) || (state == CAPTURE);
    core_init  = (state == INIT);
    core_step  = (state == STEP);
    core_round = core_step ? r : '0;
    core_final = core_step && (r == 4'(NROUNDS));
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state     <= IDLE;
      r         <= '0;
      result    <= '0;
      bcnt      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state     <= INIT;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
          end else if (load_key || load_text) begin
            done      <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
          end else if (read_ok) begin
            result <= shifted;
            bcnt   <= bcnt + 1'b1;
            if (last_byte) begin
              out_valid <= 1'b0;
              out       <= '0;
            end else begin
              out <= shifted[BLK_W-1 -: 8];
            end
          end
        end
        INIT: begin
          r     <= 4'd1;
          state <= STEP;
        end
        STEP: begin
          if (core_ack) begin
            if (r == 4'(NROUNDS)) begin
              result <= core_result;
              state  <= CAPTURE;
            end else begin
              r <= r + 4'd1;
            end
          end
        end
        CAPTURE: begin
          state     <= DONE;
          done      <= 1'b1;
          out_valid <= 1'b1;
          out       <= result[BLK_W-1 -: 8];
          bcnt      <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Directed bench for aes_seq_ctrl with a behavioural AES-128 round core that
// answers the request/acknowledge handshake with a programmable delay.
module tb_aes_seq_ctrl;
  import aes_pkg::*;

  localparam int unsigned BW = 128;
  localparam int unsigned NR = 10;
  localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] TXT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] TXT2 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT2  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [3:0]    nib = '0;
  logic [3:0]    cs = '0;
  logic [7:0]    out;
  logic          out_valid, busy, done, core_init, core_step, core_final, core_ack;
  logic [3:0]    core_round;
  logic [BW-1:0] key_o, text_o, core_result;

  int n_checks = 0;
  int n_fail   = 0;

  aes_seq_ctrl #(.NROUNDS(NR), .BLK_W(BW)) dut (
    .clk(clk), .rst(rst), .in(nib), .cs(cs), .in_valid(in_valid),
    .out(out), .out_valid(out_valid), .busy(busy), .done(done),
    .key_o(key_o), .text_o(text_o), .core_init(core_init), .core_step(core_step),
    .core_round(core_round), .core_final(core_final), .core_ack(core_ack),
    .core_result(core_result)
  );

  // AES arithmetic for the behavioural round core
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [3:0] round);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t, w0, w1, w2, w3;
    for (int i = 1; i < int'(round); i++) rc = xt(rc);
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) t[rr+4*c] = b[rr+4*((c+rr)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        b[4*c]   = gmul(t[4*c], 8'd2) ^ gmul(t[4*c+1], 8'd3) ^ t[4*c+2] ^ t[4*c+3];
        b[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'd2) ^ gmul(t[4*c+2], 8'd3) ^ t[4*c+3];
        b[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'd2) ^ gmul(t[4*c+3], 8'd3);
        b[4*c+3] = gmul(t[4*c], 8'd3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'd2);
      end
    end else begin
      for (int i = 0; i < 16; i++) b[i] = t[i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  // behavioural core: ack after ack_delay extra cycles of a held request
  logic [127:0] st = '0;
  logic [127:0] rk = '0;
  logic [127:0] rk_next;
  int           ack_delay = 0;
  int           wcnt = 0;
  logic         force_ack = 1'b0;

  assign core_ack    = force_ack | (core_step && (wcnt >= ack_delay));
  assign rk_next     = next_rk(rk, core_round);
  assign core_result = aes_round(st, rk_next, core_final);

  always @(posedge clk) begin
    wcnt <= (core_step && !core_ack) ? wcnt + 1 : 0;
    if (core_init) begin
      st <= text_o ^ key_o;
      rk <= key_o;
    end else if (core_step && core_ack) begin
      st <= core_result;
      rk <= rk_next;
    end
  end

  // handshake monitor
  logic       mon_clr = 1'b0;
  int         init_cnt = 0, ack_cnt = 0, cur_steps = 0, glitch = 0;
  logic       prev_hold = 1'b0;
  logic [3:0] prev_round = '0;
  logic [3:0] rounds [16];
  logic       finals [16];
  int         steps  [16];

  always @(posedge clk) begin
    if (mon_clr) begin
      init_cnt <= 0; ack_cnt <= 0; cur_steps <= 0; glitch <= 0; prev_hold <= 1'b0;
    end else begin
      if (core_init) init_cnt <= init_cnt + 1;
      if (prev_hold && (!core_step || core_round !== prev_round)) glitch <= glitch + 1;
      prev_hold  <= core_step && !core_ack;
      prev_round <= core_round;
      if (core_step && core_ack) begin
        if (ack_cnt < 16) begin
          rounds[ack_cnt] <= core_round;
          finals[ack_cnt] <= core_final;
          steps[ack_cnt]  <= cur_steps + 1;
        end
        ack_cnt   <= ack_cnt + 1;
        cur_steps <= 0;
      end else if (core_step) begin
        cur_steps <= cur_steps + 1;
      end
    end
  end

  // all stimulus tasks start and end on a falling edge
  task automatic send(input logic [3:0] c, input logic [3:0] n);
    cs = c; nib = n; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; cs = 4'hf; nib = '0;
  endtask

  task automatic load_block(input logic [3:0] c, input logic [127:0] v);
    for (int i = 0; i < 32; i++) send(c, v[127-4*i -: 4]);
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int edges, output bit ok);
    edges = 0; ok = 1'b0;
    while (edges < budget) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic wait_round(input logic [3:0] rnd, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (core_step && core_round == rnd) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (out !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h want 00", out); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (core_init !== 1'b0) begin n_fail++; $display("FAIL reset_core_init: got %b want 0", core_init); end
    n_checks++; if (core_step !== 1'b0) begin n_fail++; $display("FAIL reset_core_step: got %b want 0", core_step); end
    n_checks++; if (core_round !== 4'd0) begin n_fail++; $display("FAIL reset_core_round: got %0d want 0", core_round); end
    n_checks++; if (core_final !== 1'b0) begin n_fail++; $display("FAIL reset_core_final: got %b want 0", core_final); end
    n_checks++; if (key_o !== '0) begin n_fail++; $display("FAIL reset_key: got %h want 0", key_o); end
    n_checks++; if (text_o !== '0) begin n_fail++; $display("FAIL reset_text: got %h want 0", text_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fips_vector();
    int edges; bit ok; logic [127:0] exp;
    ack_delay = 0;
    mon_clear();
    load_block(CMD_LOAD_KEY, KEY);
    load_block(CMD_LOAD_TEXT, TXT);
    n_checks++; if (key_o !== KEY) begin n_fail++; $display("FAIL fips_key: got %h want %h", key_o, KEY); end
    n_checks++; if (text_o !== TXT) begin n_fail++; $display("FAIL fips_text: got %h want %h", text_o, TXT); end
    send(CMD_START, 4'h0);
    n_checks++; if (core_init !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL fips_init: got init=%b busy=%b want 1 1", core_init, busy); end
    wait_done(100, edges, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL fips_done_timeout: got done=%b want 1", done); end
    n_checks++; if (edges !== 2 + NR) begin n_fail++; $display("FAIL fips_latency: got %0d want %0d", edges, 2 + NR); end
    n_checks++; if (init_cnt !== 1) begin n_fail++; $display("FAIL fips_init_count: got %0d want 1", init_cnt); end
    n_checks++; if (ack_cnt !== NR) begin n_fail++; $display("FAIL fips_round_count: got %0d want %0d", ack_cnt, NR); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (rounds[i] !== 4'(i + 1)) begin n_fail++; $display("FAIL fips_round_idx[%0d]: got %0d want %0d", i, rounds[i], i + 1); end
      n_checks++; if (finals[i] !== (i == 9)) begin n_fail++; $display("FAIL fips_final[%0d]: got %b want %b", i, finals[i], i == 9); end
      n_checks++; if (steps[i] !== 1) begin n_fail++; $display("FAIL fips_step_len[%0d]: got %0d want 1", i, steps[i]); end
    end
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL fips_done_flags: got busy=%b out_valid=%b want 0 1", busy, out_valid); end
    exp = CT1;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (out !== exp[127-8*i -: 8] || out_valid !== 1'b1) begin n_fail++; $display("FAIL fips_byte[%0d]: got %h/%b want %h/1", i, out, out_valid, exp[127-8*i -: 8]); end
      send(CMD_READ, 4'h0);
    end
    n_checks++; if (out_valid !== 1'b0 || out !== 8'h00 || done !== 1'b1) begin n_fail++; $display("FAIL fips_drained: got ov=%b out=%h done=%b want 0 00 1", out_valid, out, done); end
    send(CMD_READ, 4'h0);
    n_checks++; if (out_valid !== 1'b0 || out !== 8'h00) begin n_fail++; $display("FAIL fips_extra_read: got ov=%b out=%h want 0 00", out_valid, out); end
  endtask

  task automatic test_slow_core();
    int edges; bit ok;
    ack_delay = 2;
    mon_clear();
    send(CMD_START, 4'h0);
    n_checks++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL slow_restart: got done=%b busy=%b want 0 1", done, busy); end
    wait_done(200, edges, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL slow_done_timeout: got done=%b want 1", done); end
    n_checks++; if (edges !== 2 + 3 * NR) begin n_fail++; $display("FAIL slow_latency: got %0d want %0d", edges, 2 + 3 * NR); end
    n_checks++; if (ack_cnt !== NR) begin n_fail++; $display("FAIL slow_round_count: got %0d want %0d", ack_cnt, NR); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (steps[i] !== 3) begin n_fail++; $display("FAIL slow_step_len[%0d]: got %0d want 3", i, steps[i]); end
    end
    n_checks++; if (glitch !== 0) begin n_fail++; $display("FAIL slow_round_stable: got %0d changes want 0", glitch); end
    n_checks++; if (out !== 8'h39) begin n_fail++; $display("FAIL slow_byte0: got %h want 39", out); end
  endtask

  task automatic test_load_during_busy();
    int edges; bit ok;
    ack_delay = 2;
    mon_clear();
    send(CMD_START, 4'h0);
    wait_round(4'd3, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL busyload_round3_timeout: got round=%0d want 3", core_round); end
    send(CMD_LOAD_KEY, 4'hf);
    send(CMD_LOAD_TEXT, 4'ha);
    n_checks++; if (key_o !== KEY) begin n_fail++; $display("FAIL busyload_key: got %h want %h", key_o, KEY); end
    n_checks++; if (text_o !== TXT) begin n_fail++; $display("FAIL busyload_text: got %h want %h", text_o, TXT); end
    wait_done(200, edges, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL busyload_done_timeout: got done=%b want 1", done); end
    n_checks++; if (ack_cnt !== NR) begin n_fail++; $display("FAIL busyload_round_count: got %0d want %0d", ack_cnt, NR); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (rounds[i] !== 4'(i + 1)) begin n_fail++; $display("FAIL busyload_round_idx[%0d]: got %0d want %0d", i, rounds[i], i + 1); end
    end
    n_checks++; if (out !== 8'h39) begin n_fail++; $display("FAIL busyload_byte0: got %h want 39", out); end
  endtask

  task automatic test_reload_text();
    int edges; bit ok; logic [127:0] exp; logic [127:0] t2;
    exp = CT1;
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (out !== exp[127-8*i -: 8]) begin n_fail++; $display("FAIL reload_partial_byte[%0d]: got %h want %h", i, out, exp[127-8*i -: 8]); end
      send(CMD_READ, 4'h0);
    end
    t2 = TXT2;
    send(CMD_LOAD_TEXT, t2[127:124]);
    n_checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reload_clears_done: got done=%b ov=%b want 0 0", done, out_valid); end
    load_block(CMD_LOAD_TEXT, TXT2);
    n_checks++; if (text_o !== TXT2 || key_o !== KEY) begin n_fail++; $display("FAIL reload_regs: got text=%h key=%h want %h %h", text_o, key_o, TXT2, KEY); end
    ack_delay = 0;
    send(CMD_START, 4'h0);
    wait_done(100, edges, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL reload_done_timeout: got done=%b want 1", done); end
    exp = CT2;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (out !== exp[127-8*i -: 8] || out_valid !== 1'b1) begin n_fail++; $display("FAIL reload_byte[%0d]: got %h/%b want %h/1", i, out, out_valid, exp[127-8*i -: 8]); end
      send(CMD_READ, 4'h0);
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reload_drained: got ov=%b want 0", out_valid); end
  endtask

  task automatic test_start_guard();
    int edges; bit ok; logic [127:0] kv;
    kv = KEY;
    send(CMD_CLEAR, 4'h0);
    n_checks++; if (key_o !== '0 || done !== 1'b0) begin n_fail++; $display("FAIL guard_clear: got key=%h done=%b want 0 0", key_o, done); end
    for (int i = 0; i < 31; i++) send(CMD_LOAD_KEY, kv[127-4*i -: 4]);
    load_block(CMD_LOAD_TEXT, TXT);
    mon_clear();
    send(CMD_START, 4'h0);
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || init_cnt !== 0) begin n_fail++; $display("FAIL guard_short_key: got busy=%b inits=%0d want 0 0", busy, init_cnt); end
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL guard_stray_ack: got busy=%b done=%b ov=%b want 0 0 0", busy, done, out_valid); end
    send(CMD_LOAD_KEY, kv[3:0]);
    n_checks++; if (key_o !== KEY) begin n_fail++; $display("FAIL guard_key32: got %h want %h", key_o, KEY); end
    send(CMD_START, 4'h0);
    n_checks++; if (core_init !== 1'b1) begin n_fail++; $display("FAIL guard_accept: got core_init=%b want 1", core_init); end
    wait_done(100, edges, ok);
    n_checks++; if (!ok || out !== 8'h39) begin n_fail++; $display("FAIL guard_result: got done=%b out=%h want 1 39", done, out); end
  endtask

  task automatic test_abort();
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) begin
        load_block(CMD_LOAD_KEY, KEY);
        load_block(CMD_LOAD_TEXT, TXT);
      end
      ack_delay = 2;
      mon_clear();
      send(CMD_START, 4'h0);
      wait_round(4'd5, 100, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL abort%0d_round5_timeout: got round=%0d want 5", pass, core_round); end
      if (pass == 0) begin
        send(CMD_CLEAR, 4'h0);
      end else begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      n_checks++; if (busy !== 1'b0 || core_step !== 1'b0) begin n_fail++; $display("FAIL abort%0d_stop: got busy=%b step=%b want 0 0", pass, busy, core_step); end
      n_checks++; if (dut.kcnt !== '0 || key_o !== '0) begin n_fail++; $display("FAIL abort%0d_kcnt: got kcnt=%0d key=%h want 0 0", pass, dut.kcnt, key_o); end
      n_checks++; if (done !== 1'b0 || core_round !== 4'd0) begin n_fail++; $display("FAIL abort%0d_flags: got done=%b round=%0d want 0 0", pass, done, core_round); end
      send(CMD_START, 4'h0);
      repeat (3) @(negedge clk);
      n_checks++; if (busy !== 1'b0 || init_cnt !== 1) begin n_fail++; $display("FAIL abort%0d_restart: got busy=%b inits=%0d want 0 1", pass, busy, init_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_fips_vector();
    test_slow_core();
    test_load_during_busy();
    test_reload_text();
    test_start_guard();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want completion within time limit");
    $fatal(1);
  end

endmodule
